mult_arbiter: RTL and testbench
===============================

Name: mult_arbiter

Overview:
- Shares one external pipelined 32-bit multiplier between NREQ requesters, typically two FIR filter channels.
- Each requester uses a req/gnt operand handshake and receives its own tagged product back after a fixed latency.
- Sits between the filter engines and the multiplier core, replacing each filter's private mult_a/mult_b/prod wiring.

Parameters:
- NREQ, 2, number of requesters (2..8).
- W, 32, operand/product width.
- LAT, 4, multiplier latency in cycles: operands present in cycle c give the product on mul_p in cycle c+LAT (LAT>=1).

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- req  in  NREQ  per-requester request; held with operands until gnt
- op_a  in  NREQ*W  requester i operand A at bits [i*W +: W]
- op_b  in  NREQ*W  requester i operand B, same packing
- gnt  out  NREQ  one-hot, registered; operands of that requester were captured
- rsp_valid  out  NREQ  one-hot, registered; rsp_data belongs to that requester
- rsp_data  out  W  product, shared by all requesters
- mul_a  out  W  multiplier operand A (registered)
- mul_b  out  W  multiplier operand B (registered)
- mul_vld  out  1  mul_a/mul_b carry a live operation this cycle
- mul_p  in  W  multiplier product
- busy  out  1  any operation in flight in the tag pipe

Behaviour:
- Reset values: gnt=0, rsp_valid=0, rsp_data=0, mul_a=0, mul_b=0, mul_vld=0, busy=0, rr pointer=0, tag pipe all invalid.
- Arbitration each clock edge (no FSM beyond the rr pointer and tag pipe):
  - Eligible set = req & ~gnt. A requester granted in the previous cycle is masked for one cycle, so one requester can issue at most every 2 cycles.
  - Winner = first eligible index searching from ptr, ptr+1, ... wrapping modulo NREQ.
  - On a winner: mul_a/mul_b <= winner operands, mul_vld<=1, gnt<=onehot(winner), ptr<=(winner+1) mod NREQ, push {1,winner} into the tag pipe.
  - No winner: mul_vld<=0, gnt<=0, mul_a/mul_b hold, ptr holds, push {0,x}.
- Tag pipe: LAT-deep shift register of {valid, id}; the stage read at edge c+LAT pairs with mul_p.
- Response: if the tag stage is valid, rsp_data<=mul_p and rsp_valid<=onehot(id); otherwise rsp_valid<=0 and rsp_data holds.
- Latency: gnt high in cycle c, rsp_valid high in cycle c+LAT+1, for exactly 1 cycle.
- Throughput: 1 op/cycle aggregate when 2 or more requesters are busy; ordering is in-order per requester.
- busy = OR of tag-pipe valid bits, or mul_vld.
- Boundaries:
  - req dropped before gnt: request withdrawn, nothing issued.
  - All req high: strict rotation 0,1,...,NREQ-1.
  - NREQ=1: grants every other cycle.
  - rst mid-operation: all in-flight ops discarded, no rsp_valid after reset.
  - A requester may get a new gnt while its earlier result is in flight.

Optional Feature:
- MULT_ARB_STATS_EN defined: adds output grant_cnt (NREQ*16; per-requester grant counters, saturating at 16'hFFFF).
- Also adds output stall_cnt (16; saturating count of cycles where some req was high but not granted).
- Both counters are cleared by rst.
- Undefined: these ports and the counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mult_arb_pkg:
  - IDW = clog2(NREQ), minimum 1.
  - Tag record type {valid, id}.
  - onehot/rr helper functions.
- Sub-module rr_pick: combinational round-robin picker taking eligible vector and ptr, producing winner index and found flag; reusable by other shared-resource arbiters.
- Tag pipe and operand mux stay in mult_arbiter.

Test Plan:
- Single requester: req[0]=1, op_a=3, op_b=5, LAT=4 -> gnt[0] in cycle 1, mul_vld=1 with mul_a=3/mul_b=5, rsp_valid[0] in cycle 6 with rsp_data=15 (behavioural multiplier model).
- Contention NREQ=2: both req held 8 cycles -> gnt sequence 0,1,0,1,...; rsp_valid alternates with matching products; no idle mul cycle after the first.
- Back-to-back masking: only req[1] held high -> gnt[1] every other cycle, mul_vld=0 in between.
- Reset mid-flight: 3 ops issued, rst pulsed 1 cycle before the first result -> no rsp_valid for 2*LAT cycles after reset; busy=0.
- Withdrawal/wrap NREQ=3, ptr=2: req=3'b011 -> gnt[0] then gnt[1]; req[0] dropped before gnt -> only requester 1 served.
- STATS_EN: 10 contended cycles on 2 requesters -> grant_cnt=5/5, stall_cnt=10 (the other requester waits each cycle).

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the multiplier arbiter and its round-robin picker.
// Requester ids are sized for the largest supported configuration (8 requesters).
package mult_arb_pkg;
  localparam int MAX_NREQ = 8;
  localparam int IDW_MAX  = 3;

  typedef struct packed {
    logic               valid;
    logic [IDW_MAX-1:0] id;
  } tag_t;

  function automatic int idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [MAX_NREQ-1:0] onehot(input logic [IDW_MAX-1:0] id);
    logic [MAX_NREQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

  function automatic logic [IDW_MAX-1:0] rr_next(input logic [IDW_MAX-1:0] id, input int n);
    if (int'(id) >= n - 1) return '0;
    return id + 1'b1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr_i, wrapping.
module rr_pick
  import mult_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]       elig_i,
  input  logic [IDW_MAX-1:0] ptr_i,
  output logic [IDW_MAX-1:0] win_o,
  output logic               found_o
);
  logic [MAX_NREQ-1:0] elig8, hi8, cand8;
  logic [IDW_MAX-1:0]  jj;

  always_comb begin
    elig8        = '0;
    elig8[N-1:0] = elig_i;
    hi8          = '0;
    jj           = '0;
    for (int j = 0; j < MAX_NREQ; j++) begin
      jj      = IDW_MAX'(j);
      hi8[jj] = elig8[jj] & (jj >= ptr_i);
    end
    // Nothing at/after the pointer means the search wraps to index 0.
    cand8   = (|hi8) ? hi8 : elig8;
    found_o = |cand8;
    win_o   = '0;
    for (int j = MAX_NREQ - 1; j >= 0; j--) begin
      jj = IDW_MAX'(j);
      if (cand8[jj]) win_o = jj;
    end
  end
endmodule

// File: rtl/mult_arbiter.sv
// Shares one pipelined multiplier between NREQ requesters with tagged, in-order responses.
// Optional MULT_ARB_STATS_EN adds saturating grant_cnt/stall_cnt statistics outputs.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 32,
  parameter int LAT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] op_a,
  input  logic [NREQ*W-1:0] op_b,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_data,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  output logic              mul_vld,
  input  logic [W-1:0]      mul_p,
  output logic              busy
`ifdef MULT_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0] grant_cnt,
  output logic [15:0]        stall_cnt
`endif
);
  logic [IDW_MAX-1:0] ptr_q, ptr_d, id_q, win;
  logic               found, mul_vld_q, busy_w;
  logic [NREQ-1:0]    gnt_q, gnt_d, rsp_valid_q, rsp_d;
  logic [W-1:0]       mul_a_q, mul_b_q, rsp_data_q;
  logic [W-1:0]       opa_arr [MAX_NREQ];
  logic [W-1:0]       opb_arr [MAX_NREQ];
  tag_t               tag_q   [LAT];

  for (genvar g = 0; g < MAX_NREQ; g++) begin : g_unpack
    if (g < NREQ) begin : g_live
      assign opa_arr[g] = op_a[g*W +: W];
      assign opb_arr[g] = op_b[g*W +: W];
    end else begin : g_pad
      assign opa_arr[g] = '0;
      assign opb_arr[g] = '0;
    end
  end

  rr_pick #(.N(NREQ)) u_pick (
    .elig_i  (req & ~gnt_q),
    .ptr_i   (ptr_q),
    .win_o   (win),
    .found_o (found)
  );

  for (genvar g = 0; g < NREQ; g++) begin : g_oh
    assign gnt_d[g] = found && (win == IDW_MAX'(g));
    assign rsp_d[g] = tag_q[LAT-1].valid && (tag_q[LAT-1].id == IDW_MAX'(g));
  end

  assign ptr_d = found ? rr_next(win, NREQ) : ptr_q;

  always_comb begin
    busy_w = mul_vld_q;
    for (int k = 0; k < LAT; k++) busy_w = busy_w | tag_q[k].valid;
  end

  // Issue stage: operands onto the multiplier bus; the tag pipe trails it by LAT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      gnt_q       <= '0;
      mul_vld_q   <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      id_q        <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
    end else begin
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      mul_vld_q <= found;
      if (found) begin
        mul_a_q <= opa_arr[win];
        mul_b_q <= opb_arr[win];
        id_q    <= win;
      end
      tag_q[0].valid <= mul_vld_q;
      tag_q[0].id    <= id_q;
      for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
      // Response stage: the oldest tag lines up with the product now on mul_p.
      rsp_valid_q <= rsp_d;
      if (tag_q[LAT-1].valid) rsp_data_q <= mul_p;
    end
  end

  assign gnt       = gnt_q;
  assign mul_vld   = mul_vld_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_w;

`ifdef MULT_ARB_STATS_EN
  logic [15:0] stall_q;

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    logic [15:0] cnt_q;
    always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else if (gnt_d[g] && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 1'b1;
    end
    assign grant_cnt[g*16 +: 16] = cnt_q;
  end

  // A stall cycle is one where some requester is asking but is not the one granted.
  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else if (|(req & ~gnt_d) && stall_q != 16'hFFFF) stall_q <= stall_q + 1'b1;
  end

  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: requester models push expected products, a monitor pops them.
module tb_mult_arbiter;
  localparam int NREQ = 3;
  localparam int W    = 32;
  localparam int LAT  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] op_a = '0, op_b = '0;
  logic [NREQ-1:0]   gnt, rsp_valid;
  logic [W-1:0]      rsp_data, mul_a, mul_b, mul_p;
  logic              mul_vld, busy;
`ifdef MULT_ARB_STATS_EN
  logic [NREQ*16-1:0] grant_cnt;
  logic [15:0]        stall_cnt;
`endif

  always #5 clk = ~clk;

  mult_arbiter #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_vld   (mul_vld),
    .mul_p     (mul_p),
    .busy      (busy)
`ifdef MULT_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  // Behavioural pipelined multiplier: operands in cycle c appear on mul_p in cycle c+LAT.
  logic [W-1:0] mp [LAT];
  always @(posedge clk) begin
    mp[0] <= mul_a * mul_b;
    for (int k = 1; k < LAT; k++) mp[k] <= mp[k-1];
  end
  assign mul_p = mp[LAT-1];

  int errors = 0;
  int checks = 0;
  logic [W-1:0]    exp_q [NREQ][$];
  logic [W-1:0]    opa   [NREQ][8];
  logic [W-1:0]    opb   [NREQ][8];
  int              nops  [NREQ];
  int              idx   [NREQ];
  logic [NREQ-1:0] en = '0;
  int              gseq  [$];
  logic            vseq  [$];
  logic [NREQ-1:0] rvseq [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req_v);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req_v);
    checks++;
    if (act != req_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req_v);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (en[i] && idx[i] < nops[i]) begin
        req[i]          = 1'b1;
        op_a[i*W +: W]  = opa[i][idx[i]];
        op_b[i*W +: W]  = opb[i][idx[i]];
      end else begin
        req[i]          = 1'b0;
        op_a[i*W +: W]  = '0;
        op_b[i*W +: W]  = '0;
      end
    end
  endtask

  task automatic load(input int i, input int n);
    nops[i] = n;
    idx[i]  = 0;
    en[i]   = 1'b1;
  endtask

  task automatic clear_seq();
    gseq.delete();
    vseq.delete();
    rvseq.delete();
  endtask

  // One clock: record the bus, capture the granted operation as an expected product.
  task automatic cyc();
    int g;
    @(negedge clk);
    g = -1;
    for (int i = 0; i < NREQ; i++) if (gnt[i]) g = i;
    if ($countones(gnt) > 1) check("gnt_onehot", 64'(gnt), 64'(0));
    gseq.push_back(g);
    vseq.push_back(mul_vld);
    rvseq.push_back(rsp_valid);
    if (g >= 0) begin
      if (en[g] && idx[g] < nops[g]) begin
        check("mul_a", 64'(mul_a), 64'(opa[g][idx[g]]));
        check("mul_b", 64'(mul_b), 64'(opb[g][idx[g]]));
        exp_q[g].push_back(opa[g][idx[g]] * opb[g][idx[g]]);
        idx[g]++;
      end else begin
        chk_int("spurious_gnt", g, -1);
      end
    end
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic check_drained();
    for (int i = 0; i < NREQ; i++) chk_int("drained", exp_q[i].size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = '0;
    for (int i = 0; i < NREQ; i++) begin
      nops[i] = 0;
      idx[i]  = 0;
      exp_q[i].delete();
    end
    drive();
    repeat (2) @(negedge clk);
    check("rst_gnt", 64'(gnt), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_data", 64'(rsp_data), 64'(0));
    check("rst_mul_a", 64'(mul_a), 64'(0));
    check("rst_mul_b", 64'(mul_b), 64'(0));
    check("rst_mul_vld", 64'(mul_vld), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
`ifdef MULT_ARB_STATS_EN
    check("rst_grant_cnt", 64'(grant_cnt), 64'(0));
    check("rst_stall_cnt", 64'(stall_cnt), 64'(0));
`endif
    rst = 1'b0;
    clear_seq();
  endtask

  // Monitor: every response must match the oldest outstanding product of its requester.
  initial begin
    int r;
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid != '0) begin
        if ($countones(rsp_valid) != 1) begin
          check("rsp_onehot", 64'(rsp_valid), 64'(0));
        end else begin
          r = 0;
          for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) r = i;
          if (exp_q[r].size() == 0) begin
            check("rsp_unexpected", 64'(rsp_valid), 64'(0));
          end else begin
            e = exp_q[r].pop_front();
            check("rsp_data", 64'(rsp_data), 64'(e));
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      nops[i] = 0;
      idx[i]  = 0;
    end
    @(negedge clk);
    do_reset();

    // Single requester: 3*5 with gnt in cycle 0 and the response LAT+1 cycles later.
    opa[0][0] = 32'd3; opb[0][0] = 32'd5;
    load(0, 1);
    drive();
    run(LAT + 4);
    chk_int("single_gnt", gseq[0], 0);
    check("single_mul_vld", 64'(vseq[0]), 64'(1));
    chk_int("single_gnt_once", gseq[1], -1);
    check("single_rsp_early", 64'(rvseq[LAT]), 64'(0));
    check("single_rsp_time", 64'(rvseq[LAT+1]), 64'(3'b001));
    check("single_rsp_once", 64'(rvseq[LAT+2]), 64'(0));

    // Contention on requesters 0 and 1: strict alternation, no idle multiplier cycle.
    check_drained();
    do_reset();
    opa[0][0] = 32'd2;          opb[0][0] = 32'd7;
    opa[0][1] = 32'd100;        opb[0][1] = 32'd3;
    opa[0][2] = 32'h0000_FFFF;  opb[0][2] = 32'h0001_0001;
    opa[0][3] = 32'hFFFF_FFFF;  opb[0][3] = 32'd2;
    opa[1][0] = 32'd6;          opb[1][0] = 32'd6;
    opa[1][1] = 32'd123;        opb[1][1] = 32'd0;
    opa[1][2] = 32'hFFFF_FFFF;  opb[1][2] = 32'hFFFF_FFFF;
    opa[1][3] = 32'h0001_2345;  opb[1][3] = 32'h0000_0100;
    load(0, 4);
    load(1, 4);
    drive();
    run(8 + LAT + 3);
    for (int k = 0; k < 8; k++) begin
      chk_int("cont_gnt", gseq[k], k % 2);
      check("cont_mul_vld", 64'(vseq[k]), 64'(1));
      check("cont_rsp_order", 64'(rvseq[k+LAT+1]), 64'(1 << (k % 2)));
    end
    chk_int("cont_idle_after", gseq[8], -1);

    // A lone requester holding req is masked every other cycle.
    check_drained();
    do_reset();
    opa[1][0] = 32'd9;          opb[1][0] = 32'd9;
    opa[1][1] = 32'd0;          opb[1][1] = 32'd5;
    opa[1][2] = 32'h8000_0000;  opb[1][2] = 32'd2;
    load(1, 3);
    drive();
    run(5 + LAT + 3);
    for (int k = 0; k < 5; k++) begin
      chk_int("mask_gnt", gseq[k], (k % 2 == 0) ? 1 : -1);
      check("mask_mul_vld", 64'(vseq[k]), 64'((k % 2 == 0) ? 1 : 0));
    end

    // Reset while three operations are in flight: no response may surface afterwards.
    check_drained();
    do_reset();
    opa[0][0] = 32'd7;  opb[0][0] = 32'd8;
    opa[0][1] = 32'd11; opb[0][1] = 32'd13;
    opa[1][0] = 32'd4;  opb[1][0] = 32'd4;
    load(0, 2);
    load(1, 1);
    drive();
    run(4);
    chk_int("flight_gnt0", gseq[0], 0);
    chk_int("flight_gnt1", gseq[1], 1);
    chk_int("flight_gnt2", gseq[2], 0);
    check("flight_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    en  = '0;
    drive();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) exp_q[i].delete();
    check("flight_busy_cleared", 64'(busy), 64'(0));
    clear_seq();
    run(2 * LAT);
    for (int k = 0; k < 2 * LAT; k++) check("flight_no_rsp", 64'(rvseq[k]), 64'(0));
    check("flight_busy_end", 64'(busy), 64'(0));

    // Pointer wrap from 2 back to 0, then withdrawal of a losing request.
    do_reset();
    opa[1][0] = 32'd10; opb[1][0] = 32'd10;
    load(1, 1);
    drive();
    run(2);
    chk_int("wrap_setup", gseq[0], 1);
    clear_seq();
    opa[0][0] = 32'd20; opb[0][0] = 32'd3;
    opa[1][0] = 32'd5;  opb[1][0] = 32'd5;
    load(0, 1);
    load(1, 1);
    drive();
    run(3);
    chk_int("wrap_first", gseq[0], 0);
    chk_int("wrap_second", gseq[1], 1);
    clear_seq();
    opa[0][0] = 32'd7; opb[0][0] = 32'd7;
    load(0, 1);
    drive();
    run(2);
    chk_int("wd_setup", gseq[0], 0);
    clear_seq();
    opa[0][0] = 32'd99; opb[0][0] = 32'd99;
    opa[1][0] = 32'd8;  opb[1][0] = 32'd8;
    load(0, 1);
    load(1, 1);
    drive();
    cyc();
    chk_int("wd_gnt1", gseq[0], 1);
    en[0] = 1'b0;
    drive();
    run(LAT + 4);
    for (int k = 1; k < 4; k++) chk_int("wd_no_gnt", gseq[k], -1);
    check_drained();

`ifdef MULT_ARB_STATS_EN
    // Ten contended cycles: five grants each and a stall every cycle.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      opa[0][k] = 32'(k + 1); opb[0][k] = 32'(k + 2);
      opa[1][k] = 32'(k + 3); opb[1][k] = 32'(k + 4);
    end
    load(0, 6);
    load(1, 5);
    drive();
    run(10);
    check("stats_grant0", 64'(grant_cnt[15:0]), 64'(5));
    check("stats_grant1", 64'(grant_cnt[31:16]), 64'(5));
    check("stats_grant2", 64'(grant_cnt[47:32]), 64'(0));
    check("stats_stall", 64'(stall_cnt), 64'(10));
    run(LAT + 6);
    check_drained();
`endif

    run(LAT + 4);
    check_drained();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
